psum_writeback: RTL and testbench
=================================

# psum_writeback

Output drain stage directly downstream of `systolic_array_top`. After a tile finishes, it reads the N×N partial-sum array one row at a time. It masks out rows and columns that fall beyond the active matrix bounds. It then streams the surviving fp32 words, with their computed byte addresses, over a valid/ready write port toward output memory. Row-major order means a tiled M×COUT result lands linearly at `out_base`.

## Interface
- `N`, 64, systolic array dimension (rows = columns)
- `DATA_W`, 32, psum word width (fp32 bit pattern, passed through untouched)
- `ADDR_W`, 32, write address width
- `DIM_W`, 16, width of tile origin and bound inputs

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; captures tile parameters when idle
- `m0`, `c0`  in  DIM_W each  global row / column origin of the tile
- `m_active`, `cout_active`  in  DIM_W each  matrix bounds; `cout_active` is also the output row stride
- `out_base`  in  ADDR_W  byte base address of the output matrix
- `busy`  out  1  high from the cycle after an accepted start through the last transfer
- `done`  out  1  one-cycle pulse at completion
- `psum_rd_en`  out  1  row read request
- `psum_rd_row`  out  $clog2(N)  row index being read
- `psum_rd_data`  in  N*DATA_W  row contents, valid exactly one cycle after `psum_rd_en`; column c is at bits [c*DATA_W +: DATA_W]
- `wb_valid`  out  1  write word valid
- `wb_ready`  in  1  sink accepts the word
- `wb_addr`  out  ADDR_W  byte address
- `wb_data`  out  DATA_W  psum word

## Operation
- States: IDLE, FETCH, WAIT, STREAM, DONE.
- IDLE:
  - On `start`, latch all tile inputs.
  - Compute `rows = min(N, m_active-m0)` and `cols = min(N, cout_active-c0)`, both signed.
  - If `rows<=0` or `cols<=0`, go to DONE. Otherwise clear row counter r and go to FETCH.
- FETCH: assert `psum_rd_en` with `psum_rd_row=r` for one cycle, then go to WAIT.
- WAIT: latch `psum_rd_data` into an N-word row buffer, clear column counter c, then go to STREAM.
- STREAM:
  - Drive `wb_valid=1`, `wb_data=buf[c]`, `wb_addr = out_base + (((m0+r)*cout_active + (c0+c)) << 2)`.
  - Address arithmetic is unsigned, truncated modulo 2^ADDR_W.
  - On handshake (`wb_valid && wb_ready`):
    - if `c<cols-1`, increment c;
    - else if `r<rows-1`, increment r and go to FETCH;
    - else go to DONE.
- DONE: pulse `done=1` for one cycle, `busy=0`, then go to IDLE.
- Columns `>= cols` and rows `>= rows` are never emitted. The block never reads rows `>= rows`.
- `start` outside IDLE is ignored. Tile inputs are sampled only on an accepted start.

## Timing
- Reset values:
  - state IDLE;
  - `busy=0`, `done=0`, `psum_rd_en=0`, `psum_rd_row=0`;
  - `wb_valid=0`, `wb_addr=0`, `wb_data=0`;
  - all counters 0.
- Start accepted at edge t:
  - FETCH in cycle t+1, WAIT in t+2, first `wb_valid` in t+3.
  - `busy=1` from t+1.
- Per row: 2 overhead cycles plus `cols` transfer cycles when `wb_ready` is held high. There is no prefetch overlap.
- Last handshake in cycle e: `done=1` and `busy=0` in cycle e+1. The block can accept a new `start` in cycle e+2.
- Empty tile: `done` in cycle t+1. No `psum_rd_en`, no `wb_valid`.
- Backpressure: while `wb_valid && !wb_ready`, `wb_addr` and `wb_data` hold stable and counters hold.
- `wb_valid` never drops without a handshake, except on `rst`.
- Reset mid-operation: in the next cycle all outputs return to their reset values. No `done` pulse occurs, and the partial stream is abandoned.
- `rst` and `start` in the same cycle: `rst` wins and the start is lost.

## Test plan
- Full tile, with N=4, m0=0, c0=0, m_active=4, cout_active=4, out_base=0x1000, `wb_ready` held 1:
  - 16 writes at 0x1000..0x103C, step 4, row-major;
  - data equals the psum words;
  - `done` exactly once, 25 cycles after the start edge.
- Partial tile, with N=4, m0=4, c0=0, m_active=6, cout_active=3, base=0:
  - 6 writes at 0x30, 0x34, 0x38, 0x3C, 0x40, 0x44;
  - rows 2–3 are never read.
- Backpressure, full 4×4 tile with `wb_ready` alternating 1,0:
  - exactly 16 transfers, in order;
  - `wb_addr` and `wb_data` are stable across every stalled cycle.
- Empty tile, with m0=8, m_active=6:
  - `done` in cycle t+1;
  - zero `psum_rd_en` and zero `wb_valid` cycles.
- Reset mid-stream, `rst` after the 5th transfer:
  - next cycle `busy=0`, `wb_valid=0`, and no `done`;
  - a fresh start then completes all 16 transfers.
- Start while busy, second `start` pulsed during STREAM with different m0:
  - ignored;
  - addresses still follow the first tile's m0;
  - exactly one `done`.

Source files
------------

// File: rtl/psum_writeback.sv
// psum_writeback: drains the systolic partial-sum array row by row and streams
// the in-bounds fp32 words, with their row-major byte addresses, to output memory.
module psum_writeback #(
  parameter int unsigned N      = 64,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM_W-1:0]       m0,
  input  logic [DIM_W-1:0]       c0,
  input  logic [DIM_W-1:0]       m_active,
  input  logic [DIM_W-1:0]       cout_active,
  input  logic [ADDR_W-1:0]      out_base,
  output logic                   busy,
  output logic                   done,
  output logic                   psum_rd_en,
  output logic [$clog2(N)-1:0]   psum_rd_row,
  input  logic [N*DATA_W-1:0]    psum_rd_data,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data
);

  localparam int unsigned RW = $clog2(N);
  localparam logic signed [DIM_W:0] N_S = (DIM_W+1)'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    m0_q, m0_d;
  logic [DIM_W-1:0]    c0_q, c0_d;
  logic [DIM_W-1:0]    stride_q, stride_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [RW-1:0]       rows_m1_q, rows_m1_d;
  logic [RW-1:0]       cols_m1_q, cols_m1_d;
  logic [RW-1:0]       r_q, r_d;
  logic [RW-1:0]       c_q, c_d;
  logic [N*DATA_W-1:0] buf_q, buf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [RW-1:0]       rd_row_q, rd_row_d;
  logic                wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;

  logic signed [DIM_W:0] row_span, col_span;
  logic                  row_empty, col_empty;
  logic [RW-1:0]         rows_lim, cols_lim;
  logic [ADDR_W-1:0]     lin_idx, addr_nxt;
  logic [DATA_W-1:0]     data_nxt;

  // Active tile extent from the raw inputs: signed span clamped to the array size
  always_comb begin
    row_span  = $signed({1'b0, m_active}) - $signed({1'b0, m0});
    col_span  = $signed({1'b0, cout_active}) - $signed({1'b0, c0});
    row_empty = row_span[DIM_W] || (row_span == '0);
    col_empty = col_span[DIM_W] || (col_span == '0);
    rows_lim  = (row_span >= N_S) ? RW'(N - 1) : RW'(row_span - (DIM_W+1)'(1));
    cols_lim  = (col_span >= N_S) ? RW'(N - 1) : RW'(col_span - (DIM_W+1)'(1));
  end

  // Next-state, counters and registered-output values
  always_comb begin
    state_d    = state_q;
    m0_d       = m0_q;
    c0_d       = c0_q;
    stride_d   = stride_q;
    base_d     = base_q;
    rows_m1_d  = rows_m1_q;
    cols_m1_d  = cols_m1_q;
    r_d        = r_q;
    c_d        = c_q;
    buf_d      = buf_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    lin_idx    = '0;
    addr_nxt   = '0;
    data_nxt   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m0_d      = m0;
          c0_d      = c0;
          stride_d  = cout_active;
          base_d    = out_base;
          rows_m1_d = rows_lim;
          cols_m1_d = cols_lim;
          r_d       = '0;
          c_d       = '0;
          state_d   = (row_empty || col_empty) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        buf_d   = psum_rd_data;
        c_d     = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (wb_valid_q && wb_ready) begin
          if (c_q != cols_m1_q) begin
            c_d = c_q + RW'(1);
          end else if (r_q != rows_m1_q) begin
            r_d     = r_q + RW'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Row-major byte address and buffered word for the next (r, c)
    lin_idx  = (ADDR_W'(m0_q) + ADDR_W'(r_d)) * ADDR_W'(stride_q)
             + ADDR_W'(c0_q) + ADDR_W'(c_d);
    addr_nxt = base_q + (lin_idx << 2);
    for (int unsigned i = 0; i < N; i++) begin
      if (RW'(i) == c_d) data_nxt = buf_d[i*DATA_W +: DATA_W];
    end

    busy_d     = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_STREAM);
    done_d     = (state_d == S_DONE);
    rd_en_d    = (state_d == S_FETCH);
    rd_row_d   = r_d;
    wb_valid_d = (state_d == S_STREAM);
    if (state_d == S_STREAM) begin
      wb_addr_d = addr_nxt;
      wb_data_d = data_nxt;
    end
  end

  // Control state, counters and outputs; reset abandons any tile in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      m0_q       <= '0;
      c0_q       <= '0;
      stride_q   <= '0;
      base_q     <= '0;
      rows_m1_q  <= '0;
      cols_m1_q  <= '0;
      r_q        <= '0;
      c_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_row_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      m0_q       <= m0_d;
      c0_q       <= c0_d;
      stride_q   <= stride_d;
      base_q     <= base_d;
      rows_m1_q  <= rows_m1_d;
      cols_m1_q  <= cols_m1_d;
      r_q        <= r_d;
      c_q        <= c_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_row_q   <= rd_row_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Row buffer is always rewritten before use, so it carries no reset
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign psum_rd_en  = rd_en_q;
  assign psum_rd_row = rd_row_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_psum_writeback.sv
// tb_psum_writeback: table-driven, randomized and hand-sequenced checks of psum_writeback.
module tb_psum_writeback;

  localparam int unsigned N      = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DIM_W  = 16;
  localparam int unsigned RW     = $clog2(N);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [DIM_W-1:0]    m0 = '0, c0 = '0, m_active = '0, cout_active = '0;
  logic [ADDR_W-1:0]   out_base = '0;
  logic                busy, done, psum_rd_en, wb_valid;
  logic [RW-1:0]       psum_rd_row;
  logic [N*DATA_W-1:0] psum_rd_data = '0;
  logic                wb_ready = 1'b1;
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;

  psum_writeback #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .m0(m0), .c0(c0),
    .m_active(m_active), .cout_active(cout_active), .out_base(out_base),
    .busy(busy), .done(done), .psum_rd_en(psum_rd_en), .psum_rd_row(psum_rd_row),
    .psum_rd_data(psum_rd_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    int          m0;
    int          c0;
    int          ma;
    int          ca;
    logic [31:0] base;
    int          mode;     // 0: ready high, 1: ready alternates 1,0
    int          exp_n;    // hand-computed number of writes
    int          exp_lat;  // hand-computed start-to-done latency, -1 = not checked
  } vec_t;

  logic [31:0] psum_arr [N][N];
  xfer_t       got[$];
  xfer_t       exp_q[$];
  int          cyc = 0;
  int          checks = 0, errors = 0;
  int          ready_mode = 0, alt = 0;
  int          done_cnt = 0, done_cyc = 0, rd_cnt = 0, valid_cnt = 0, max_row = -1;
  int          t_cyc = 0, exp_rows = 0, exp_cols = 0;
  bit          prev_stall = 1'b0, rd_last = 1'b0;
  logic [31:0] prev_addr, prev_data;
  logic [RW-1:0] row_last = '0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sink, monitor and psum array responder, all acting mid-cycle
  always @(negedge clk) begin
    case (ready_mode)
      0:       wb_ready = 1'b1;
      1:       begin wb_ready = (alt == 0); alt ^= 1; end
      default: wb_ready = 1'($urandom_range(0, 1));
    endcase
    if (prev_stall) begin
      chk("stall_valid", longint'(wb_valid), 1);
      chk("stall_addr", longint'(wb_addr), longint'(prev_addr));
      chk("stall_data", longint'(wb_data), longint'(prev_data));
    end
    prev_stall = wb_valid && !wb_ready && !rst;
    prev_addr  = wb_addr;
    prev_data  = wb_data;
    if (wb_valid && wb_ready && !rst) got.push_back('{wb_addr, wb_data});
    if (wb_valid) valid_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (psum_rd_en) begin
      rd_cnt++;
      if (int'(psum_rd_row) > max_row) max_row = int'(psum_rd_row);
    end
    if (rd_last) begin
      for (int c = 0; c < N; c++) psum_rd_data[c*DATA_W +: DATA_W] = psum_arr[row_last][c];
    end else begin
      psum_rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    rd_last  = psum_rd_en;
    row_last = psum_rd_row;
  end

  // Reference: clamp spans, then enumerate in-bounds words in row-major order
  task automatic build_expected(input int tm0, input int tc0, input int tma, input int tca,
                                input logic [31:0] tbase);
    longint a;
    exp_q.delete();
    exp_rows = tma - tm0;
    exp_cols = tca - tc0;
    if (exp_rows > int'(N)) exp_rows = N;
    if (exp_cols > int'(N)) exp_cols = N;
    if (exp_rows > 0 && exp_cols > 0) begin
      for (int r = 0; r < exp_rows; r++) begin
        for (int c = 0; c < exp_cols; c++) begin
          a = longint'(tbase) + ((longint'(tm0) + r) * tca + tc0 + c) * 4;
          exp_q.push_back('{32'(a), psum_arr[r][c]});
        end
      end
    end
  endtask

  task automatic begin_tile(input int tm0, input int tc0, input int tma, input int tca,
                            input logic [31:0] tbase, input int mode);
    bit nonempty;
    ready_mode = mode;
    alt        = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) psum_arr[r][c] = $urandom();
    build_expected(tm0, tc0, tma, tca, tbase);
    nonempty = (exp_rows > 0 && exp_cols > 0);
    @(negedge clk);
    got.delete();
    done_cnt = 0; rd_cnt = 0; valid_cnt = 0; max_row = -1;
    m0 = 16'(tm0); c0 = 16'(tc0); m_active = 16'(tma); cout_active = 16'(tca);
    out_base = tbase;
    start = 1'b1;
    @(posedge clk);
    #1;
    t_cyc = cyc;
    start = 1'b0;
    chk("busy_after_start", longint'(busy), longint'(nonempty));
  endtask

  task automatic finish_tile(input bit check_lat, input int exp_lat);
    int n;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (4) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("xfer_count", got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("wb_addr", longint'(got[i].addr), longint'(exp_q[i].addr));
      chk("wb_data", longint'(got[i].data), longint'(exp_q[i].data));
    end
    chk("rows_read", rd_cnt, (exp_rows > 0 && exp_cols > 0) ? exp_rows : 0);
    chk("max_row_read", max_row, (exp_rows > 0 && exp_cols > 0) ? exp_rows - 1 : -1);
    if (ready_mode == 0) chk("valid_cycles", valid_cnt, exp_q.size());
    if (check_lat) chk("done_latency", done_cyc - t_cyc + 1, exp_lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   tm0, tc0, tma, tca;

    vecs[0] = '{0,  0,  4,   4,   32'h0000_1000, 0, 16, 25};  // full tile
    vecs[1] = '{4,  0,  6,   3,   32'h0000_0000, 0, 6,  11};  // partial tile
    vecs[2] = '{8,  0,  6,   4,   32'h0000_0000, 0, 0,  1};   // empty rows
    vecs[3] = '{0,  5,  4,   5,   32'h0000_0040, 0, 0,  1};   // empty columns
    vecs[4] = '{3,  3,  4,   4,   32'h0000_0100, 0, 1,  4};   // single word
    vecs[5] = '{10, 20, 100, 200, 32'hFFFF_FF00, 0, 16, 25};  // clamp + address wrap
    vecs[6] = '{0,  0,  4,   4,   32'h0000_1000, 1, 16, -1};  // alternating backpressure

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_rd_en", longint'(psum_rd_en), 0);
    chk("rst_rd_row", longint'(psum_rd_row), 0);
    chk("rst_valid", longint'(wb_valid), 0);
    chk("rst_addr", longint'(wb_addr), 0);
    chk("rst_data", longint'(wb_data), 0);

    foreach (vecs[i]) begin
      begin_tile(vecs[i].m0, vecs[i].c0, vecs[i].ma, vecs[i].ca, vecs[i].base, vecs[i].mode);
      finish_tile(vecs[i].exp_lat >= 0, vecs[i].exp_lat);
      chk("vec_writes", got.size(), vecs[i].exp_n);
    end

    // Randomized tiles under random backpressure
    for (int k = 0; k < 24; k++) begin
      tm0 = $urandom_range(0, 9);
      tma = $urandom_range(0, 12);
      tc0 = $urandom_range(0, 9);
      tca = $urandom_range(0, 12);
      begin_tile(tm0, tc0, tma, tca, $urandom() & 32'hFFFF_FFFC, 2);
      finish_tile(1'b0, 0);
    end

    // Reset after the fifth transfer abandons the stream without done
    begin_tile(0, 0, 4, 4, 32'h0000_2000, 0);
    for (int i = 0; i < 200 && got.size() < 5; i++) @(posedge clk);
    chk("reached_5_xfers", got.size() >= 5, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_valid", longint'(wb_valid), 0);
    chk("midrst_done", longint'(done), 0);
    chk("midrst_rd_en", longint'(psum_rd_en), 0);
    chk("midrst_addr", longint'(wb_addr), 0);
    repeat (5) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    begin_tile(0, 0, 4, 4, 32'h0000_2000, 0);
    finish_tile(1'b1, 25);

    // Second start during streaming is ignored; inputs stay changed afterwards
    begin_tile(0, 0, 4, 4, 32'h0000_3000, 0);
    for (int i = 0; i < 200 && got.size() < 2; i++) @(posedge clk);
    @(negedge clk);
    m0    = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_tile(1'b1, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
